bpu_resolve: RTL and testbench
==============================

BPU_RESOLVE -- requirements
Module: bpu_resolve

Interface
- REQ-001: Parameter DEPTH, default 8, is the number of in-flight prediction entries; it SHALL be a power of two, 2..32.
- REQ-002: Parameter IDX_WIDTH, default 9, is the PHT index and global-history width.
- REQ-003: in_Clk  input  1  single clock; all state is updated on the rising edge.
- REQ-004: in_Rst_N  input  1  reset, asynchronous, active-low.
- REQ-005: in_pred_valid  input  1  fetch-side prediction record presented this cycle.
- REQ-006: in_pred_pc  input  IDX_WIDTH  low PC bits of the predicted branch.
- REQ-007: in_pred_ghr  input  IDX_WIDTH  global history used for this prediction.
- REQ-008: in_pred_taken  input  1  predicted direction.
- REQ-009: out_pred_ready  output  1  queue can accept a record; high when not full.
- REQ-010: in_res_valid  input  1  execute stage resolves the oldest in-flight branch.
- REQ-011: in_res_taken  input  1  actual branch outcome.
- REQ-012: out_upd_valid  output  1  PHT update strobe, one cycle wide.
- REQ-013: out_upd_addr  output  IDX_WIDTH  PHT index to update, equal to pc XOR ghr of the resolved entry.
- REQ-014: out_upd_taken  output  1  actual outcome to train with.
- REQ-015: out_mispredict  output  1  one-cycle flush pulse.
- REQ-016: out_restore_ghr  output  IDX_WIDTH  corrected history, valid while out_mispredict is high.
- REQ-017: out_underflow  output  1  sticky error flag, set by a resolve while the queue is empty.

Function
- REQ-018: A record SHALL be pushed when in_pred_valid and out_pred_ready are both high; a push while full is dropped and the state is left unchanged.
- REQ-019: A resolve SHALL pop the oldest entry, in FIFO order.
- REQ-020: Update outputs SHALL be registered, with exactly one cycle from the resolve edge to out_upd_valid.
- REQ-021: out_upd_addr SHALL be the stored pc XOR the stored ghr, computed from the popped entry.
- REQ-022: out_mispredict SHALL assert when the stored predicted direction differs from in_res_taken.
- REQ-023: out_restore_ghr SHALL be {stored_ghr[IDX_WIDTH-2:0], in_res_taken}.
- REQ-024: On a mispredict, all remaining younger entries SHALL be discarded, leaving the queue empty the next cycle.
- REQ-025: A push in the same cycle as a mispredicting resolve SHALL be discarded, because it is wrong-path.
- REQ-026: A push in the same cycle as a correct resolve SHALL succeed even when the queue is full; the occupancy is unchanged.
- REQ-027: A resolve while empty SHALL leave out_upd_valid and out_mispredict low and SHALL set out_underflow.
- REQ-028: out_underflow SHALL clear only on reset.
- REQ-029: Read and write pointers SHALL wrap modulo DEPTH.
- REQ-030: Occupancy SHALL be held in a counter of width log2(DEPTH)+1.
- REQ-031: out_pred_ready SHALL be low exactly when occupancy equals DEPTH.

Reset
- REQ-032: While in_Rst_N is low, pointers and occupancy SHALL be 0.
- REQ-033: While in_Rst_N is low, out_pred_ready SHALL be 1.
- REQ-034: While in_Rst_N is low, out_upd_valid, out_upd_addr, out_upd_taken, out_mispredict, out_restore_ghr and out_underflow SHALL be 0.
- REQ-035: Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
- REQ-036: Entry storage contents need not be reset.

Configuration
- REQ-037: Macro BPU_RESOLVE_STATS_EN, when defined, SHALL add outputs out_stat_total[15:0] and out_stat_miss[15:0].
- REQ-038: With the macro defined, out_stat_total SHALL count valid resolves and out_stat_miss SHALL count mispredicts.
- REQ-039: Both statistics counters SHALL saturate at 16'hFFFF and SHALL reset to 0.
- REQ-040: Without the macro, both statistics ports SHALL be present and tied to 0, with no counter logic.

Verification
- REQ-041: Push pc=9'h005, ghr=9'h003, pred=1, then resolve taken=1 -> next cycle out_upd_valid=1, out_upd_addr=9'h006, out_upd_taken=1, out_mispredict=0.
- REQ-042: Same push, then resolve taken=0 -> out_mispredict=1 and out_restore_ghr=9'h006.
- REQ-043: Fill 8 entries, then continue pushing -> out_pred_ready=0 and the 9th push is dropped; 8 correct resolves return the entries in push order.
- REQ-044: With 3 entries queued, mispredict the oldest while pushing in the same cycle -> occupancy is 0 the next cycle and out_pred_ready=1.
- REQ-045: Resolve with the queue empty -> no update strobe and out_underflow=1, which stays high until reset.
- REQ-046: Pull in_Rst_N low asynchronously mid-stream with 4 entries queued -> outputs clear immediately and a following resolve sets out_underflow.

Source files
------------

// File: rtl/bpu_resolve.sv
// Branch-prediction resolve queue: holds in-flight predictions, pops the oldest on resolve and
// emits registered PHT-update and flush outputs. Optional counters under BPU_RESOLVE_STATS_EN.
module bpu_resolve #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned IDX_WIDTH = 9
) (
   input  logic                 in_Clk,
   input  logic                 in_Rst_N,
   input  logic                 in_pred_valid,
   input  logic [IDX_WIDTH-1:0] in_pred_pc,
   input  logic [IDX_WIDTH-1:0] in_pred_ghr,
   input  logic                 in_pred_taken,
   output logic                 out_pred_ready,
   input  logic                 in_res_valid,
   input  logic                 in_res_taken,
   output logic                 out_upd_valid,
   output logic [IDX_WIDTH-1:0] out_upd_addr,
   output logic                 out_upd_taken,
   output logic                 out_mispredict,
   output logic [IDX_WIDTH-1:0] out_restore_ghr,
   output logic                 out_underflow,
   output logic [15:0]          out_stat_total,
   output logic [15:0]          out_stat_miss
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [IDX_WIDTH-1:0] pc_mem  [DEPTH];
   logic [IDX_WIDTH-1:0] ghr_mem [DEPTH];
   logic [DEPTH-1:0]     pred_mem;

   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0]   count_q;

   logic                 upd_valid_q, upd_taken_q, mispredict_q, underflow_q;
   logic [IDX_WIDTH-1:0] upd_addr_q, restore_ghr_q;

   logic empty, res_fire, miss, push;

   assign empty          = (count_q == '0);
   assign out_pred_ready = (count_q != FULL_CNT);
   assign res_fire       = in_res_valid & ~empty;
   assign miss           = res_fire & (pred_mem[rd_ptr_q] != in_res_taken);
   // A correct resolve frees a slot this cycle, so a full queue may still accept; a
   // mispredict makes any same-cycle record wrong-path.
   assign push           = in_pred_valid & ~miss & (out_pred_ready | res_fire);

   always_ff @(posedge in_Clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= in_pred_pc;
         ghr_mem[wr_ptr_q]  <= in_pred_ghr;
         pred_mem[wr_ptr_q] <= in_pred_taken;
      end
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (miss) begin
         rd_ptr_q <= rd_ptr_q + 1'b1;
         wr_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= '0;
      end else begin
         if (res_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
         case ({push, res_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         upd_valid_q   <= 1'b0;
         upd_addr_q    <= '0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         restore_ghr_q <= '0;
         underflow_q   <= 1'b0;
      end else begin
         upd_valid_q  <= res_fire;
         mispredict_q <= miss;
         if (res_fire) begin
            upd_addr_q    <= pc_mem[rd_ptr_q] ^ ghr_mem[rd_ptr_q];
            upd_taken_q   <= in_res_taken;
            restore_ghr_q <= {ghr_mem[rd_ptr_q][IDX_WIDTH-2:0], in_res_taken};
         end
         if (in_res_valid && empty) underflow_q <= 1'b1;
      end
   end

   assign out_upd_valid   = upd_valid_q;
   assign out_upd_addr    = upd_addr_q;
   assign out_upd_taken   = upd_taken_q;
   assign out_mispredict  = mispredict_q;
   assign out_restore_ghr = restore_ghr_q;
   assign out_underflow   = underflow_q;

`ifdef BPU_RESOLVE_STATS_EN
   logic [15:0] stat_total_q, stat_miss_q;

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         stat_total_q <= '0;
         stat_miss_q  <= '0;
      end else begin
         if (res_fire && stat_total_q != 16'hFFFF) stat_total_q <= stat_total_q + 16'd1;
         if (miss && stat_miss_q != 16'hFFFF)      stat_miss_q  <= stat_miss_q + 16'd1;
      end
   end

   assign out_stat_total = stat_total_q;
   assign out_stat_miss  = stat_miss_q;
`else
   assign out_stat_total = 16'h0000;
   assign out_stat_miss  = 16'h0000;
`endif

endmodule

// File: tb/tb_bpu_resolve.sv
// Bench for bpu_resolve: queue-based reference model compared every cycle, plus directed
// literal scenarios and a randomized traffic phase.
module tb_bpu_resolve;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned IW    = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pred_valid = 1'b0;
   logic [IW-1:0] pred_pc = '0;
   logic [IW-1:0] pred_ghr = '0;
   logic          pred_taken = 1'b0;
   logic          pred_ready;
   logic          res_valid = 1'b0;
   logic          res_taken = 1'b0;
   logic          upd_valid;
   logic [IW-1:0] upd_addr;
   logic          upd_taken;
   logic          mispredict;
   logic [IW-1:0] restore_ghr;
   logic          underflow;
   logic [15:0]   stat_total, stat_miss;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bpu_resolve #(.DEPTH(DEPTH), .IDX_WIDTH(IW)) dut (
      .in_Clk(clk), .in_Rst_N(rst_n),
      .in_pred_valid(pred_valid), .in_pred_pc(pred_pc), .in_pred_ghr(pred_ghr),
      .in_pred_taken(pred_taken), .out_pred_ready(pred_ready),
      .in_res_valid(res_valid), .in_res_taken(res_taken),
      .out_upd_valid(upd_valid), .out_upd_addr(upd_addr), .out_upd_taken(upd_taken),
      .out_mispredict(mispredict), .out_restore_ghr(restore_ghr), .out_underflow(underflow),
      .out_stat_total(stat_total), .out_stat_miss(stat_miss)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-flight entries as a plain queue.
   typedef struct {
      logic [IW-1:0] pc;
      logic [IW-1:0] ghr;
      logic          pred;
   } ent_t;

   ent_t          q[$];
   logic          exp_uv, exp_ut, exp_mp, exp_uf;
   logic [IW-1:0] exp_addr, exp_rg;

   always @(posedge clk or negedge rst_n) begin : model
      int   n;
      ent_t e;
      bit   m;
      if (!rst_n) begin
         q.delete();
         exp_uv = 0; exp_ut = 0; exp_mp = 0; exp_uf = 0; exp_addr = '0; exp_rg = '0;
      end else begin
         n = q.size();
         m = 0;
         exp_uv = 0;
         exp_mp = 0;
         if (res_valid) begin
            if (n == 0) exp_uf = 1;
            else begin
               e = q.pop_front();
               exp_uv   = 1;
               exp_addr = e.pc ^ e.ghr;
               exp_ut   = res_taken;
               m        = (e.pred != res_taken);
               exp_mp   = m;
               exp_rg   = {e.ghr[IW-2:0], res_taken};
               if (m) q.delete();
            end
         end
         if (pred_valid && !m && (n < DEPTH || (res_valid && n > 0)))
            q.push_back('{pc: pred_pc, ghr: pred_ghr, pred: pred_taken});
      end
   end

   always @(negedge clk) begin : compare
      chk("pred_ready", {31'b0, pred_ready}, {31'b0, q.size() != DEPTH});
      chk("upd_valid", {31'b0, upd_valid}, {31'b0, exp_uv});
      chk("mispredict", {31'b0, mispredict}, {31'b0, exp_mp});
      chk("underflow", {31'b0, underflow}, {31'b0, exp_uf});
      if (exp_uv) begin
         chk("upd_addr", {23'b0, upd_addr}, {23'b0, exp_addr});
         chk("upd_taken", {31'b0, upd_taken}, {31'b0, exp_ut});
      end
      if (exp_mp) chk("restore_ghr", {23'b0, restore_ghr}, {23'b0, exp_rg});
      if (!rst_n) begin
         chk("rst_upd_addr", {23'b0, upd_addr}, 32'h0);
         chk("rst_restore_ghr", {23'b0, restore_ghr}, 32'h0);
      end
`ifndef BPU_RESOLVE_STATS_EN
      chk("stat_total", {16'b0, stat_total}, 32'h0);
      chk("stat_miss", {16'b0, stat_miss}, 32'h0);
`endif
   end

   // Inputs are applied just after a rising edge and captured on the next one.
   task automatic cyc(input logic pv, input logic [IW-1:0] pc, input logic [IW-1:0] ghr,
                      input logic pt, input logic rv, input logic rt);
      pred_valid = pv; pred_pc = pc; pred_ghr = ghr; pred_taken = pt;
      res_valid = rv; res_taken = rt;
      @(posedge clk);
      #1;
      pred_valid = 0; res_valid = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      #2;
      chk("reset_ready", {31'b0, pred_ready}, 32'h1);
      chk("reset_upd_valid", {31'b0, upd_valid}, 32'h0);
      chk("reset_underflow", {31'b0, underflow}, 32'h0);
      chk("reset_restore", {23'b0, restore_ghr}, 32'h0);
      @(posedge clk); #1; rst_n = 1;

      // Correct resolve
      cyc(1, 9'h005, 9'h003, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      chk("d1_upd_valid", {31'b0, upd_valid}, 32'h1);
      chk("d1_upd_addr", {23'b0, upd_addr}, 32'h006);
      chk("d1_upd_taken", {31'b0, upd_taken}, 32'h1);
      chk("d1_mispredict", {31'b0, mispredict}, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("d1_strobe_width", {31'b0, upd_valid}, 32'h0);

      // Mispredict
      cyc(1, 9'h005, 9'h003, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("d2_mispredict", {31'b0, mispredict}, 32'h1);
      chk("d2_restore", {23'b0, restore_ghr}, 32'h006);
      chk("d2_upd_taken", {31'b0, upd_taken}, 32'h0);

      // Fill, overflow push dropped, drain in order
      for (int i = 0; i < 8; i++) cyc(1, 9'(i + 16), 9'(i), 1, 0, 0);
      chk("d3_full_ready", {31'b0, pred_ready}, 32'h0);
      cyc(1, 9'h1FF, 9'h000, 1, 0, 0);
      chk("d3_still_full", {31'b0, pred_ready}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 1, 1);
         chk("d3_order", {23'b0, upd_addr}, 32'((i + 16) ^ i));
      end
      chk("d3_empty_ready", {31'b0, pred_ready}, 32'h1);

      // Full queue: correct resolve plus push keeps it full
      for (int i = 0; i < 8; i++) cyc(1, 9'(i), 9'h0, 1, 0, 0);
      cyc(1, 9'h0AA, 9'h0, 1, 1, 1);
      chk("d4_full_hold", {31'b0, pred_ready}, 32'h0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1);
      chk("d4_last_entry", {23'b0, upd_addr}, 32'h0AA);

      // Mispredict with 3 queued and a wrong-path push
      for (int i = 0; i < 3; i++) cyc(1, 9'(i + 1), 9'h0, 1, 0, 0);
      cyc(1, 9'h077, 9'h0, 1, 1, 0);
      chk("d5_mispredict", {31'b0, mispredict}, 32'h1);
      chk("d5_ready", {31'b0, pred_ready}, 32'h1);

      // Resolve with queue empty
      cyc(0, 0, 0, 0, 1, 1);
      chk("d6_no_strobe", {31'b0, upd_valid}, 32'h0);
      chk("d6_underflow", {31'b0, underflow}, 32'h1);
      repeat (3) cyc(1, 9'h011, 9'h0, 1, 0, 0);
      chk("d6_sticky", {31'b0, underflow}, 32'h1);

      // Asynchronous reset mid-stream (queue holds 4)
      cyc(1, 9'h012, 9'h0, 1, 0, 0);
      #2;
      rst_n = 0;
      #1;
      chk("d7_async_ready", {31'b0, pred_ready}, 32'h1);
      chk("d7_async_underflow", {31'b0, underflow}, 32'h0);
      chk("d7_async_upd_valid", {31'b0, upd_valid}, 32'h0);
      @(posedge clk); #1; rst_n = 1;
      cyc(0, 0, 0, 0, 1, 1);
      chk("d7_underflow_after", {31'b0, underflow}, 32'h1);
      chk("d7_no_strobe", {31'b0, upd_valid}, 32'h0);

      // Randomized traffic with varying push/resolve pressure
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int pp, rp;
         pp = (i < 1000) ? 90 : (i < 2000) ? 50 : 70;
         rp = (i < 1000) ? 30 : (i < 2000) ? 70 : 45;
         cyc(($urandom_range(99) < pp), 9'($urandom), 9'($urandom),
             ($urandom_range(9) != 0), ($urandom_range(99) < rp), ($urandom_range(9) != 0));
         if (i == 1500) do_reset();
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
